// File: rtl/usb_frame_ctrl.sv
// Frame-assembly controller: sequences ULPI bytes (one per new_byte strobe)
// into a sync + command + payload frame and hands it to a consumer over a
// valid/ready handshake. Flags bad sync bytes, inter-byte timeouts and bytes
// that arrive while a completed frame is still held.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   usb_data_in       received byte, qualified by new_byte
//   new_byte          one-cycle strobe for usb_data_in
//   frame_ready       consumer accepts the held frame
//   frame_data        assembled frame, first byte in the MSBs
//   frame_valid       frame_data complete and stable
//   busy              a frame is in progress or held
//   byte_count        bytes captured in the current frame
//   err_sync          pulse: first byte was not the sync byte
//   err_timeout       pulse: frame aborted on inter-byte gap
//   err_overrun       pulse: byte dropped while holding a frame
module usb_frame_ctrl #(
    parameter int unsigned PAYLOAD_BYTES  = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned FW            = (PAYLOAD_BYTES + 2) * 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    usb_data_in,
    input  logic          new_byte,
    input  logic          frame_ready,
    output logic [FW-1:0] frame_data,
    output logic          frame_valid,
    output logic          busy,
    output logic [6:0]    byte_count,
    output logic          err_sync,
    output logic          err_timeout,
    output logic          err_overrun
);

    localparam int unsigned GW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] LAST_BEFORE  = 7'(PAYLOAD_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_HOLD
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  gap_cnt;
    logic [GW-1:0]  gap_nxt;
    logic [FW-1:0]  data_nxt;
    logic [6:0]     count_nxt;
    logic           err_sync_nxt;
    logic           err_timeout_nxt;
    logic           err_overrun_nxt;

    logic           is_sync;
    logic           gap_expired;
    logic [FW-1:0]  data_shift;
    logic [FW-1:0]  data_start;

    assign is_sync     = new_byte && (usb_data_in == SYNC_BYTE);
    assign gap_expired = !new_byte && (gap_cnt == GAP_LAST);
    assign data_shift  = {frame_data[FW-9:0], usb_data_in};
    // A sync byte starts from a cleared frame so no stale bits survive.
    assign data_start  = {{(FW-8){1'b0}}, usb_data_in};

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            byte_count  <= '0;
            err_sync    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_nxt;
            frame_data  <= data_nxt;
            frame_valid <= (state_nxt == ST_HOLD);
            busy        <= (state_nxt != ST_IDLE);
            byte_count  <= count_nxt;
            err_sync    <= err_sync_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (is_sync) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (new_byte)         state_nxt = ST_PAYLOAD;
                else if (gap_expired) state_nxt = ST_IDLE;
            end
            ST_PAYLOAD: begin
                if (new_byte) begin
                    if (byte_count == LAST_BEFORE) state_nxt = ST_HOLD;
                end else if (gap_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A byte arriving with the transfer is judged as if in IDLE.
                if (frame_ready) state_nxt = is_sync ? ST_HDR : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, counters and error pulses
    always_comb begin
        data_nxt        = frame_data;
        count_nxt       = byte_count;
        gap_nxt         = '0;
        err_sync_nxt    = 1'b0;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_sync) begin
                    data_nxt  = data_start;
                    count_nxt = 7'd1;
                end else if (new_byte) begin
                    err_sync_nxt = 1'b1;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (new_byte) begin
                    data_nxt  = data_shift;
                    count_nxt = byte_count + 7'd1;
                end else if (gap_expired) begin
                    err_timeout_nxt = 1'b1;
                    count_nxt       = '0;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    count_nxt = '0;
                    if (is_sync) begin
                        data_nxt  = data_start;
                        count_nxt = 7'd1;
                    end else if (new_byte) begin
                        err_sync_nxt = 1'b1;
                    end
                end else if (new_byte) begin
                    err_overrun_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_frame_ctrl.sv
// Directed test for usb_frame_ctrl at default parameters.
module tb_usb_frame_ctrl;

    localparam int FW = 528;

    logic          clk;
    logic          rst;
    logic [7:0]    usb_data_in;
    logic          new_byte;
    logic          frame_ready;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          busy;
    logic [6:0]    byte_count;
    logic          err_sync;
    logic          err_timeout;
    logic          err_overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int pulses;
    logic [FW-1:0] exp_frame;
    logic [FW-1:0] saved_frame;

    usb_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .usb_data_in (usb_data_in),
        .new_byte    (new_byte),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .busy        (busy),
        .byte_count  (byte_count),
        .err_sync    (err_sync),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        usb_data_in = b;
        new_byte    = 1'b1;
        tick();
        new_byte    = 1'b0;
        usb_data_in = 8'h00;
    endtask

    task automatic send_pay(input logic [7:0] b);
        exp_frame = {exp_frame[FW-9:0], b};
        send_byte(b);
    endtask

    // Sync, command and the first n payload bytes (base + i*step).
    task automatic start_frame(input logic [7:0] cmd, input int base, input int step, input int n);
        exp_frame = '0;
        send_pay(8'hA5);
        send_pay(cmd);
        for (int i = 0; i < n; i++) send_pay(8'(base + i * step));
    endtask

    initial begin
        rst = 1'b1; new_byte = 1'b0; usb_data_in = 8'h00; frame_ready = 1'b0;
        exp_frame = '0;
        tick(); tick();
        check("rst_valid", 64'(frame_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(byte_count), 64'(0));
        check("rst_data", 64'(frame_data == '0), 64'(1));
        check("rst_errs", 64'({err_sync, err_timeout, err_overrun}), 64'(0));
        rst = 1'b0;
        tick();

        // Nominal frame, consumer always ready
        frame_ready = 1'b1;
        start_frame(8'h3C, 0, 1, 63);
        check("nom_pre_valid", 64'(frame_valid), 64'(0));
        check("nom_pre_count", 64'(byte_count), 64'(65));
        send_pay(8'h3F);
        check("nom_valid", 64'(frame_valid), 64'(1));
        check("nom_count", 64'(byte_count), 64'(66));
        check("nom_hdr", 64'(frame_data[527:512]), 64'(16'hA53C));
        check("nom_last", 64'(frame_data[7:0]), 64'(8'h3F));
        check("nom_frame", 64'(frame_data === exp_frame), 64'(1));
        tick();
        check("nom_valid_drop", 64'(frame_valid), 64'(0));
        check("nom_count_clr", 64'(byte_count), 64'(0));
        check("nom_busy_clr", 64'(busy), 64'(0));
        check("nom_data_kept", 64'(frame_data[7:0]), 64'(8'h3F));
        frame_ready = 1'b0;

        // Bad sync bytes
        send_byte(8'h5A);
        check("bs1_err", 64'(err_sync), 64'(1));
        check("bs1_count", 64'(byte_count), 64'(0));
        check("bs1_data_kept", 64'(frame_data[7:0]), 64'(8'h3F));
        send_byte(8'h00);
        check("bs2_err", 64'(err_sync), 64'(1));
        check("bs2_busy", 64'(busy), 64'(0));
        send_byte(8'hA5);
        check("bs3_err", 64'(err_sync), 64'(0));
        check("bs3_count", 64'(byte_count), 64'(1));
        check("bs3_busy", 64'(busy), 64'(1));
        check("bs3_data", 64'(frame_data[63:0]), 64'(8'hA5));
        tick();
        check("bs_no_pulse", 64'(err_sync), 64'(0));

        // Backpressure and overrun: finish this frame with the consumer stalled
        exp_frame = 528'hA5;
        send_pay(8'h77);
        for (int i = 0; i < 64; i++) send_pay(8'(8'h10 + i * 3));
        check("bp_valid", 64'(frame_valid), 64'(1));
        check("bp_frame", 64'(frame_data === exp_frame), 64'(1));
        send_byte(8'h11);
        check("ovr_pulse", 64'(err_overrun), 64'(1));
        check("ovr_valid", 64'(frame_valid), 64'(1));
        check("ovr_frame", 64'(frame_data === exp_frame), 64'(1));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (err_overrun) pulses++;
        end
        check("ovr_single", 64'(pulses), 64'(0));
        check("ovr_hold_valid", 64'(frame_valid), 64'(1));
        check("ovr_hold_count", 64'(byte_count), 64'(66));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("bp_xfer_valid", 64'(frame_valid), 64'(0));
        check("bp_xfer_busy", 64'(busy), 64'(0));

        // Simultaneous transfer and sync byte
        start_frame(8'h01, 5, 1, 64);
        check("sim1_valid", 64'(frame_valid), 64'(1));
        frame_ready = 1'b1;
        send_byte(8'hA5);
        frame_ready = 1'b0;
        check("sim1_valid_drop", 64'(frame_valid), 64'(0));
        check("sim1_count", 64'(byte_count), 64'(1));
        check("sim1_busy", 64'(busy), 64'(1));
        check("sim1_errs", 64'({err_sync, err_overrun}), 64'(0));
        check("sim1_data", 64'(frame_data[63:0]), 64'(8'hA5));
        // Simultaneous transfer and bad byte
        exp_frame = 528'hA5;
        send_pay(8'h02);
        for (int i = 0; i < 64; i++) send_pay(8'(200 - i));
        check("sim2_frame", 64'(frame_data === exp_frame), 64'(1));
        frame_ready = 1'b1;
        send_byte(8'h00);
        frame_ready = 1'b0;
        check("sim2_err", 64'(err_sync), 64'(1));
        check("sim2_busy", 64'(busy), 64'(0));
        check("sim2_valid", 64'(frame_valid), 64'(0));
        check("sim2_count", 64'(byte_count), 64'(0));
        check("sim2_frame_kept", 64'(frame_data === exp_frame), 64'(1));

        // Timeout boundary
        start_frame(8'h44, 0, 2, 20);
        check("to_count", 64'(byte_count), 64'(22));
        pulses = 0;
        for (int i = 0; i < 1023; i++) begin
            tick();
            if (err_timeout) pulses++;
        end
        send_byte(8'h99);
        check("to_edge_pulses", 64'(pulses), 64'(0));
        check("to_edge_err", 64'(err_timeout), 64'(0));
        check("to_edge_count", 64'(byte_count), 64'(23));
        check("to_edge_busy", 64'(busy), 64'(1));
        pulses = 0;
        for (int i = 0; i < 1023; i++) begin
            tick();
            if (err_timeout || !busy) pulses++;
        end
        check("to_pre_fire", 64'(pulses), 64'(0));
        tick();
        check("to_fire", 64'(err_timeout), 64'(1));
        check("to_count_clr", 64'(byte_count), 64'(0));
        check("to_busy", 64'(busy), 64'(0));
        tick();
        check("to_pulse_end", 64'(err_timeout), 64'(0));

        // Reset mid-frame
        start_frame(8'h55, 1, 1, 28);
        check("rm_count", 64'(byte_count), 64'(30));
        rst = 1'b1;
        send_byte(8'h12);
        rst = 1'b0;
        check("rm_data", 64'(frame_data == '0), 64'(1));
        check("rm_outs", 64'({frame_valid, busy, byte_count, err_sync, err_timeout, err_overrun}), 64'(0));
        frame_ready = 1'b1;
        start_frame(8'hC3, 9, 5, 64);
        check("rm_valid", 64'(frame_valid), 64'(1));
        check("rm_count_full", 64'(byte_count), 64'(66));
        check("rm_frame", 64'(frame_data === exp_frame), 64'(1));
        saved_frame = exp_frame;
        tick();
        check("rm_xfer", 64'(frame_valid), 64'(0));
        check("rm_kept", 64'(frame_data === saved_frame), 64'(1));
        frame_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/usb_frame_ctrl.md
# usb_frame_ctrl

Frame-assembly controller between the ULPI byte receiver and the packet consumer. It sequences incoming USB bytes (one per `new_byte` strobe) into a fixed 528-bit frame: sync byte, command byte, then 64 payload bytes. It presents the completed frame to the downstream consumer with a valid/ready handshake. It also rejects bad sync bytes, aborts stalled frames, and flags bytes that arrive while a frame is still held.

## Interface
- `PAYLOAD_BYTES`, default 64: payload bytes per frame.
- `SYNC_BYTE`, default 8'hA5: required first byte of every frame.
- `TIMEOUT_CYCLES`, default 1024: maximum idle gap between bytes inside a frame.
- Frame width `FW` = (PAYLOAD_BYTES+2)*8, which is 528 at the defaults.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `usb_data_in`  in  8  received byte; valid only when `new_byte`=1.
- `new_byte`  in  1  one-cycle strobe: `usb_data_in` holds a new byte.
- `frame_ready`  in  1  consumer accepts the frame this cycle.
- `frame_data`  out  FW  assembled frame; first received byte in [FW-1:FW-8], last payload byte in [7:0].
- `frame_valid`  out  1  `frame_data` is complete and stable.
- `busy`  out  1  a frame is in progress or held (state ≠ IDLE).
- `byte_count`  out  7  bytes captured in the current frame, 0..PAYLOAD_BYTES+2.
- `err_sync`  out  1  one-cycle pulse: first byte ≠ SYNC_BYTE, byte discarded.
- `err_timeout`  out  1  one-cycle pulse: frame aborted on inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse: byte arrived in HOLD and was dropped.

## Operation
- States:
  - IDLE: waiting for the sync byte.
  - HDR: sync byte held, waiting for the command byte.
  - PAYLOAD: receiving payload bytes.
  - HOLD: frame complete, `frame_valid`=1.
- IDLE, on `new_byte`:
  - If the byte = SYNC_BYTE: shift it in, set byte_count=1, go to HDR.
  - Otherwise: pulse `err_sync`, leave frame_data and byte_count unchanged, stay in IDLE.
- HDR, on `new_byte`: shift in the command byte (any value accepted), byte_count=2, go to PAYLOAD.
- PAYLOAD, on `new_byte`: shift in the byte and increment byte_count. The byte that brings byte_count to PAYLOAD_BYTES+2 moves the state to HOLD.
- Shift rule: frame_data ← {frame_data[FW-9:0], usb_data_in}. After a full frame, the sync byte sits in the MSBs.
- HOLD:
  - `frame_valid`=1; frame_data frozen.
  - `frame_ready`=1: the frame is transferred. Go to IDLE and clear byte_count to 0. frame_data keeps its contents until the next sync byte.
  - `new_byte`=1 with `frame_ready`=0: the byte is dropped and `err_overrun` pulses.
  - `new_byte` and `frame_ready` in the same cycle: the transfer completes, and the byte is evaluated exactly as in IDLE. A matching sync byte goes to HDR with byte_count=1; any other byte pulses `err_sync` and the state goes to IDLE.
- Timeout:
  - A gap counter runs only in HDR and PAYLOAD. It clears on every captured byte and on entry to HDR.
  - If TIMEOUT_CYCLES consecutive cycles pass without `new_byte`, pulse `err_timeout`, clear byte_count, and go to IDLE.
  - If `new_byte` arrives in the same cycle the limit is reached, the byte wins and no timeout fires.
- New sync start: frame_data is cleared to 0 on the edge that captures a sync byte, before the shift, so partial frames never carry stale bits.

## Timing
- All outputs are registered. Reset values: frame_data=0, frame_valid=0, busy=0, byte_count=0, err_*=0, state IDLE, gap counter 0.
- `rst` overrides everything in the same edge, including mid-frame and in HOLD. The held frame is lost and no error pulses.
- A byte is captured on the rising edge where `new_byte`=1. byte_count reflects it the following cycle.
- Latency: `frame_valid` rises 1 cycle after the cycle carrying the last payload byte.
- Back-to-back `new_byte` on consecutive cycles is supported. The minimum frame time is 66 cycles from sync strobe to `frame_valid`.
- Transfer occurs on the edge where `frame_valid`&&`frame_ready`; `frame_valid` is 0 the next cycle. `frame_ready` is ignored outside HOLD.
- Each error pulse is exactly 1 cycle long, in the cycle after the triggering edge.
- Timeout at default: the last byte is at cycle t, with no strobes in t+1..t+1024. `err_timeout`=1 in cycle t+1025, and busy=0 from the same cycle.

## Test plan
- Nominal frame: A5, 3C, then payload 00..3F on consecutive cycles, `frame_ready`=1 → `frame_valid` for exactly 1 cycle, 1 cycle after byte 3F; frame_data[527:512]=16'hA53C; frame_data[7:0]=8'h3F; byte_count=66 while valid, then 0.
- Bad sync: bytes 5A, 00, then A5 → `err_sync` pulses twice; byte_count=1 only after A5; state HDR.
- Backpressure/overrun: complete a frame with `frame_ready`=0; send byte 11; hold for 10 cycles → `err_overrun` one pulse, frame_data unchanged; `frame_ready`=1 → valid drops next cycle.
- Simultaneous: in HOLD, assert `frame_ready` and `new_byte`=A5 in one cycle → frame transferred, next state HDR with byte_count=1, no error pulse. Repeat with byte 00 → transfer, `err_sync` pulses, state IDLE.
- Timeout boundary: stop after 20 payload bytes. A strobe at gap cycle 1024 keeps the frame alive. A gap of exactly 1024 idle cycles → `err_timeout` pulses, byte_count=0, busy=0.
- Reset mid-frame: `rst` after 30 bytes → all outputs 0 next cycle; a fresh 66-byte frame then completes normally.
